full_hash_param: RTL and testbench
==================================

FULL_HASH_PARAM -- requirements
Module: full_hash_param

Interface
REQ-001 SHALL have parameter BEAT_BYTES, default 1, input bytes per beat; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter HASH_W, default 32, hash width; legal values 32, 64.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  begin a new message.
REQ-006 SHALL have port mode  input  1  algorithm select: 0 = FNV-1a (XOR then multiply), 1 = FNV-1 (multiply then XOR); sampled only when start is accepted.
REQ-007 SHALL have port Data  input  8*BEAT_BYTES  beat payload; byte k is Data[8k+7:8k], and byte 0 is processed first.
REQ-008 SHALL have port Keep  input  BEAT_BYTES  per-byte valid; a byte whose Keep bit is 0 is skipped.
REQ-009 SHALL have port F_dr  input  1  source has a beat on Data/Keep.
REQ-010 SHALL have port End_of_File  input  1  message end request.
REQ-011 SHALL have port R_h  output  HASH_W  final hash.
REQ-012 SHALL have port Length  output  32  count of bytes hashed.
REQ-013 SHALL have port F_rtr  output  1  block ready to accept a beat or End_of_File.
REQ-014 SHALL have port H_ready  output  1  R_h and Length are valid.

Function
REQ-015 SHALL implement the states IDLE, WAIT, PROC and DONE.
REQ-016 SHALL treat start as accepted only in IDLE or DONE; on acceptance it SHALL load h to the offset basis, clear Length, latch mode, and go to WAIT.
REQ-017 SHALL ignore start in WAIT and PROC; the message in progress continues unchanged.
REQ-018 SHALL use offset basis 0x811C9DC5 and prime 0x01000193 for HASH_W=32.
REQ-019 SHALL use offset basis 0xCBF29CE484222325 and prime 0x00000100000001B3 for HASH_W=64.
REQ-020 SHALL compute each multiply modulo 2^HASH_W.
REQ-021 SHALL drive F_rtr=1 only in WAIT.
REQ-022 SHALL, in WAIT, move to DONE when End_of_File=1 at a rising edge; this takes priority over F_dr if both are 1.
REQ-023 SHALL, in WAIT with End_of_File=0 and F_dr=1 at a rising edge, accept the beat, latch Data and Keep, and go to PROC.
REQ-024 SHALL spend exactly BEAT_BYTES cycles in PROC, one byte index per cycle in ascending order, with F_rtr=0 throughout.
REQ-025 SHALL, in the PROC cycle for byte k, update h by the selected algorithm and increment Length only if Keep[k]=1; otherwise h and Length SHALL hold.
REQ-026 SHALL return from PROC to WAIT, so that for a beat accepted at edge T, F_rtr is 1 again in cycle T+BEAT_BYTES+1.
REQ-027 SHALL ignore Data, Keep, F_dr and End_of_File outside WAIT.
REQ-028 SHALL enter DONE in the cycle after End_of_File is accepted, with H_ready=1, R_h=h and Length as counted.
REQ-029 SHALL hold the DONE outputs until rst or an accepted start.
REQ-030 SHALL drive R_h=0, Length=0 and H_ready=0 in IDLE, WAIT and PROC.
REQ-031 SHALL, for an empty message (End_of_File accepted with no beat), give R_h equal to the offset basis and Length=0.
REQ-032 SHALL, for a beat with Keep all 0, still spend BEAT_BYTES cycles in PROC, with h and Length unchanged.
REQ-033 SHALL let Length wrap modulo 2^32.
REQ-034 SHALL make start accepted in DONE clear H_ready in the next cycle.

Reset
REQ-035 SHALL, while rst=1 at a rising edge, regardless of state (including mid-PROC), go to IDLE with F_rtr=0, H_ready=0, R_h=0 and Length=0.
REQ-036 SHALL discard any partial message on reset; a fresh start is required afterwards.
REQ-037 SHALL respond to start only at the first edge with rst=0.

Verification
REQ-038 SHALL verify empty message: HASH_W=32, mode=0, start, then End_of_File -> R_h=0x811C9DC5, Length=0, H_ready=1.
REQ-039 SHALL verify "a" with BEAT_BYTES=1, mode=0 -> R_h=0xE40C292C, Length=1.
REQ-040 SHALL verify "a" with HASH_W=64, mode=0 -> R_h=0xAF63DC4C8601EC8C.
REQ-041 SHALL verify "foobar" with BEAT_BYTES=4: beat 1 is "foob" with Keep=1111, beat 2 is "ar" with Keep=0011 -> mode=0 gives R_h=0xBF9CF968, mode=1 gives R_h=0x31F0B262, Length=6 in both cases, and F_rtr is low 4 cycles per beat.
REQ-042 SHALL verify a start pulse mid-"foobar" -> ignored and R_h=0xBF9CF968.
REQ-043 SHALL verify rst pulsed after byte 3 of "foobar", then a fresh start and the full message -> R_h=0xBF9CF968, Length=6.

Source files
------------

// File: rtl/full_hash_param.sv
// Streaming FNV-1 / FNV-1a hasher: one beat of BEAT_BYTES bytes is accepted in WAIT, then folded one byte per cycle.
// Latency: BEAT_BYTES cycles per beat (F_rtr low meanwhile); result valid the cycle after End_of_File, held until start/rst.
module full_hash_param #(
  parameter int BEAT_BYTES = 1,
  parameter int HASH_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic [8*BEAT_BYTES-1:0] Data,
  input  logic [BEAT_BYTES-1:0]   Keep,
  input  logic                    F_dr,
  input  logic                    End_of_File,
  output logic [HASH_W-1:0]       R_h,
  output logic [31:0]             Length,
  output logic                    F_rtr,
  output logic                    H_ready
);

  typedef enum logic [1:0] {IDLE, WAIT, PROC, DONE} state_t;

  localparam int IDX_W = (BEAT_BYTES > 1) ? $clog2(BEAT_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEAT_BYTES - 1);
  localparam logic [HASH_W-1:0] BASIS = (HASH_W == 64) ? HASH_W'(64'hCBF2_9CE4_8422_2325)
                                                       : HASH_W'(32'h811C_9DC5);
  localparam logic [HASH_W-1:0] PRIME = (HASH_W == 64) ? HASH_W'(64'h0000_0100_0000_01B3)
                                                       : HASH_W'(32'h0100_0193);

  state_t                  state_q, state_d;
  logic [HASH_W-1:0]       h_q, h_d;
  logic [31:0]             len_q, len_d;
  logic                    mode_q, mode_d;
  logic [8*BEAT_BYTES-1:0] data_q, data_d;
  logic [BEAT_BYTES-1:0]   keep_q, keep_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic                    start_ok;
  logic                    beat_take;
  logic [7:0]              cur_byte;
  logic                    cur_keep;
  logic [HASH_W-1:0]       byte_ext;
  logic [HASH_W-1:0]       h_fnv1a;
  logic [HASH_W-1:0]       h_fnv1;

  assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
  assign beat_take = (state_q == WAIT) && !End_of_File && F_dr;

  // Byte lane selected by the PROC index; bytes go out lowest lane first.
  always_comb begin
    cur_byte = 8'h00;
    cur_keep = 1'b0;
    for (int k = 0; k < BEAT_BYTES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_byte = data_q[8*k +: 8];
        cur_keep = keep_q[k];
      end
    end
  end

  assign byte_ext = {{(HASH_W-8){1'b0}}, cur_byte};
  assign h_fnv1a  = (h_q ^ byte_ext) * PRIME;
  assign h_fnv1   = (h_q * PRIME) ^ byte_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q    <= '0;
      len_q  <= '0;
      mode_q <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      idx_q  <= '0;
    end else begin
      h_q    <= h_d;
      len_q  <= len_d;
      mode_q <= mode_d;
      data_q <= data_d;
      keep_q <= keep_d;
      idx_q  <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_ok) state_d = WAIT;
      WAIT: begin
        if (End_of_File)  state_d = DONE;
        else if (F_dr)    state_d = PROC;
      end
      PROC: if (idx_q == LAST_IDX) state_d = WAIT;
      DONE: if (start_ok) state_d = WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    h_d    = h_q;
    len_d  = len_q;
    mode_d = mode_q;
    data_d = data_q;
    keep_d = keep_q;
    idx_d  = idx_q;
    if (start_ok) begin
      h_d    = BASIS;
      len_d  = '0;
      mode_d = mode;
    end
    if (beat_take) begin
      data_d = Data;
      keep_d = Keep;
      idx_d  = '0;
    end
    if (state_q == PROC) begin
      idx_d = idx_q + IDX_W'(1);
      if (cur_keep) begin
        h_d   = mode_q ? h_fnv1 : h_fnv1a;
        len_d = len_q + 32'd1;
      end
    end
  end

  always_comb begin
    F_rtr   = (state_q == WAIT);
    H_ready = (state_q == DONE);
    R_h     = (state_q == DONE) ? h_q : '0;
    Length  = (state_q == DONE) ? len_q : '0;
  end

endmodule

// File: tb/tb_full_hash_param.sv
// Bench for full_hash_param: a 4-byte/32-bit instance plus 1-byte instances at 32 and 64 bits sharing stimulus.
`timescale 1ns/1ps
module tb_full_hash_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        a_rst, a_start, a_mode, a_fdr, a_eof;
  logic [31:0] a_data;
  logic [3:0]  a_keep;
  logic [31:0] a_rh, a_len;
  logic        a_rtr, a_hrdy;

  logic        s_rst, s_start, s_mode, s_fdr, s_eof;
  logic [7:0]  s_data;
  logic [0:0]  s_keep;
  logic [31:0] b_rh, b_len;
  logic        b_rtr, b_hrdy;
  logic [63:0] c_rh;
  logic [31:0] c_len;
  logic        c_rtr, c_hrdy;

  full_hash_param #(.BEAT_BYTES(4), .HASH_W(32)) u_a (
    .clk(clk), .rst(a_rst), .start(a_start), .mode(a_mode), .Data(a_data), .Keep(a_keep),
    .F_dr(a_fdr), .End_of_File(a_eof), .R_h(a_rh), .Length(a_len), .F_rtr(a_rtr), .H_ready(a_hrdy));

  full_hash_param #(.BEAT_BYTES(1), .HASH_W(32)) u_b (
    .clk(clk), .rst(s_rst), .start(s_start), .mode(s_mode), .Data(s_data), .Keep(s_keep),
    .F_dr(s_fdr), .End_of_File(s_eof), .R_h(b_rh), .Length(b_len), .F_rtr(b_rtr), .H_ready(b_hrdy));

  full_hash_param #(.BEAT_BYTES(1), .HASH_W(64)) u_c (
    .clk(clk), .rst(s_rst), .start(s_start), .mode(s_mode), .Data(s_data), .Keep(s_keep),
    .F_dr(s_fdr), .End_of_File(s_eof), .R_h(c_rh), .Length(c_len), .F_rtr(c_rtr), .H_ready(c_hrdy));

  typedef struct {
    logic [63:0] h;
    logic [31:0] len;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];
  exp_t c_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_fnv32(input logic m, input logic [7:0] msg[$]);
    logic [31:0] h;
    h = 32'h811C9DC5;
    foreach (msg[i]) begin
      if (m) h = (h * 32'h01000193) ^ {24'd0, msg[i]};
      else   h = (h ^ {24'd0, msg[i]}) * 32'h01000193;
    end
    return h;
  endfunction

  function automatic exp_t mk(input logic [63:0] h, input logic [31:0] len);
    exp_t e;
    e.h   = h;
    e.len = len;
    return e;
  endfunction

  // ---------------- 4-byte instance drivers ----------------
  task automatic a_wait_rtr(input string tag);
    int n = 0;
    while (a_rtr !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (a_rtr !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_rtr_timeout: F_rtr=%b after %0d cycles, required 1", tag, a_rtr, n);
    end
  endtask

  task automatic a_go(input logic m);
    a_start = 1'b1;
    a_mode  = m;
    tick();
    a_start = 1'b0;
    a_mode  = ~m;
  endtask

  task automatic a_beat(input logic [31:0] d, input logic [3:0] k, input string tag);
    int low = 0;
    a_wait_rtr(tag);
    a_data = d;
    a_keep = k;
    a_fdr  = 1'b1;
    tick();
    a_fdr  = 1'b0;
    a_data = $urandom;
    a_keep = 4'($urandom);
    while (a_rtr !== 1'b1 && low < 20) begin
      low++;
      tick();
    end
    total++;
    if (low != 4) begin
      bad++;
      $display("FAIL %s_rtr_low: F_rtr low %0d cycles, required 4", tag, low);
    end
  endtask

  task automatic a_end(input string tag);
    exp_t e;
    int   n = 0;
    a_wait_rtr(tag);
    a_eof = 1'b1;
    tick();
    a_eof = 1'b0;
    while (a_hrdy !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    total++;
    if (a_hrdy !== 1'b1 || n != 0) begin
      bad++;
      $display("FAIL %s_hready: H_ready=%b after %0d cycles, required 1 after 0", tag, a_hrdy, n);
    end
    if (a_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_sb_empty: result seen with no expectation queued", tag);
    end else begin
      e = a_q.pop_front();
      total++;
      if (a_rh !== e.h[31:0]) begin
        bad++;
        $display("FAIL %s_hash: R_h=%h, required %h", tag, a_rh, e.h[31:0]);
      end
      total++;
      if (a_len !== e.len) begin
        bad++;
        $display("FAIL %s_len: Length=%0d, required %0d", tag, a_len, e.len);
      end
    end
  endtask

  // ---------------- 1-byte instances (32 and 64 bit) ----------------
  task automatic s_go(input logic m);
    s_start = 1'b1;
    s_mode  = m;
    tick();
    s_start = 1'b0;
    s_mode  = ~m;
  endtask

  task automatic s_beat(input logic [7:0] d, input logic k, input string tag);
    int low = 0;
    int n   = 0;
    while (b_rtr !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    s_data = d;
    s_keep = k;
    s_fdr  = 1'b1;
    tick();
    s_fdr  = 1'b0;
    s_data = 8'($urandom);
    while (b_rtr !== 1'b1 && low < 20) begin
      low++;
      tick();
    end
    total++;
    if (low != 1 || c_rtr !== 1'b1) begin
      bad++;
      $display("FAIL %s_rtr_low: F_rtr low %0d cycles (c_rtr=%b), required 1 (1)", tag, low, c_rtr);
    end
  endtask

  // dr is raised together with End_of_File to exercise its priority
  task automatic s_end(input logic dr, input string tag);
    exp_t eb, ec;
    s_eof  = 1'b1;
    s_fdr  = dr;
    s_data = 8'h5A;
    tick();
    s_eof = 1'b0;
    s_fdr = 1'b0;
    total++;
    if (b_hrdy !== 1'b1 || c_hrdy !== 1'b1) begin
      bad++;
      $display("FAIL %s_hready: H_ready b=%b c=%b, required 1 1", tag, b_hrdy, c_hrdy);
    end
    if (b_q.size() == 0 || c_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_sb_empty: result seen with no expectation queued", tag);
    end else begin
      eb = b_q.pop_front();
      ec = c_q.pop_front();
      total++;
      if (b_rh !== eb.h[31:0] || b_len !== eb.len) begin
        bad++;
        $display("FAIL %s_b32: R_h=%h Length=%0d, required %h %0d", tag, b_rh, b_len, eb.h[31:0], eb.len);
      end
      total++;
      if (c_rh !== ec.h || c_len !== ec.len) begin
        bad++;
        $display("FAIL %s_c64: R_h=%h Length=%0d, required %h %0d", tag, c_rh, c_len, ec.h, ec.len);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    a_rst = 1'b1; s_rst = 1'b1;
    a_start = 1'b1; s_start = 1'b1;
    tick();
    tick();
    a_rst = 1'b0; s_rst = 1'b0;
    a_start = 1'b0; s_start = 1'b0;
    total++;
    if ({a_rtr, a_hrdy, a_rh, a_len} !== '0) begin
      bad++;
      $display("FAIL reset_a: rtr=%b hrdy=%b R_h=%h Length=%0d, required all 0", a_rtr, a_hrdy, a_rh, a_len);
    end
    total++;
    if ({b_rtr, b_hrdy, b_rh, b_len, c_rtr, c_hrdy, c_rh, c_len} !== '0) begin
      bad++;
      $display("FAIL reset_bc: b rtr=%b hrdy=%b c rtr=%b hrdy=%b R_h=%h, required all 0", b_rtr, b_hrdy, c_rtr, c_hrdy, c_rh);
    end
    a_eof = 1'b1; a_fdr = 1'b1;
    tick();
    tick();
    a_eof = 1'b0; a_fdr = 1'b0;
    total++;
    if (a_rtr !== 1'b0 || a_hrdy !== 1'b0) begin
      bad++;
      $display("FAIL idle_needs_start: rtr=%b hrdy=%b, required 0 0", a_rtr, a_hrdy);
    end
  endtask

  task automatic test_empty();
    s_go(1'b0);
    total++;
    if (b_rtr !== 1'b1 || b_rh !== 32'd0 || c_hrdy !== 1'b0) begin
      bad++;
      $display("FAIL empty_wait: rtr=%b R_h=%h c_hrdy=%b, required 1 0 0", b_rtr, b_rh, c_hrdy);
    end
    b_q.push_back(mk(64'h811C9DC5, 32'd0));
    c_q.push_back(mk(64'hCBF29CE484222325, 32'd0));
    s_end(1'b0, "empty");
  endtask

  task automatic test_single_a();
    s_go(1'b0);
    b_q.push_back(mk(64'hE40C292C, 32'd1));
    c_q.push_back(mk(64'hAF63DC4C8601EC8C, 32'd1));
    s_beat(8'h61, 1'b1, "a");
    s_end(1'b0, "a");
    s_start = 1'b0; s_fdr = 1'b1; s_eof = 1'b1;
    tick();
    tick();
    tick();
    s_fdr = 1'b0; s_eof = 1'b0;
    total++;
    if (b_hrdy !== 1'b1 || b_rh !== 32'hE40C292C || c_rh !== 64'hAF63DC4C8601EC8C) begin
      bad++;
      $display("FAIL done_hold: hrdy=%b R_h=%h c=%h, required 1 e40c292c af63dc4c8601ec8c", b_hrdy, b_rh, c_rh);
    end
    s_go(1'b0);
    total++;
    if (b_hrdy !== 1'b0 || c_hrdy !== 1'b0 || b_rtr !== 1'b1) begin
      bad++;
      $display("FAIL restart_clears: hrdy b=%b c=%b rtr=%b, required 0 0 1", b_hrdy, c_hrdy, b_rtr);
    end
    b_q.push_back(mk(64'h811C9DC5, 32'd0));
    c_q.push_back(mk(64'hCBF29CE484222325, 32'd0));
    s_end(1'b1, "eof_priority");
  endtask

  task automatic test_foobar(input logic m);
    a_go(m);
    a_q.push_back(mk(m ? 64'h31F0B262 : 64'hBF9CF968, 32'd6));
    a_beat(32'h626F6F66, 4'hF, "foobar_b1");
    a_beat(32'hDEAD7261, 4'h3, "foobar_b2");
    a_end(m ? "foobar_fnv1" : "foobar_fnv1a");
  endtask

  task automatic test_start_ignored();
    a_go(1'b0);
    a_q.push_back(mk(64'hBF9CF968, 32'd6));
    a_start = 1'b1; a_mode = 1'b1;
    tick();
    a_start = 1'b0;
    total++;
    if (a_rtr !== 1'b1) begin
      bad++;
      $display("FAIL start_in_wait: F_rtr=%b, required 1", a_rtr);
    end
    a_data = 32'h626F6F66; a_keep = 4'hF; a_fdr = 1'b1;
    tick();
    a_fdr = 1'b0;
    a_start = 1'b1; a_mode = 1'b1;
    tick();
    tick();
    a_start = 1'b0;
    a_beat(32'h00007261, 4'h3, "ign_b2");
    a_end("start_ignored");
  endtask

  task automatic test_reset_mid();
    a_go(1'b0);
    a_wait_rtr("rmid");
    a_data = 32'h626F6F66; a_keep = 4'hF; a_fdr = 1'b1;
    tick();
    a_fdr = 1'b0;
    tick();
    tick();
    tick();
    a_rst = 1'b1; a_start = 1'b1; a_mode = 1'b0;
    tick();
    total++;
    if ({a_rtr, a_hrdy, a_rh, a_len} !== '0) begin
      bad++;
      $display("FAIL reset_mid: rtr=%b hrdy=%b R_h=%h Length=%0d, required all 0", a_rtr, a_hrdy, a_rh, a_len);
    end
    a_rst = 1'b0;
    tick();
    a_start = 1'b0;
    total++;
    if (a_rtr !== 1'b1) begin
      bad++;
      $display("FAIL start_after_rst: F_rtr=%b, required 1", a_rtr);
    end
    a_q.push_back(mk(64'hBF9CF968, 32'd6));
    a_beat(32'h626F6F66, 4'hF, "rmid_b1");
    a_beat(32'h00007261, 4'h3, "rmid_b2");
    a_end("after_reset");
  endtask

  task automatic test_keep_zero();
    a_go(1'b1);
    a_q.push_back(mk(64'h811C9DC5, 32'd0));
    a_beat(32'h12345678, 4'h0, "keep0");
    a_end("keep0");
  endtask

  task automatic test_back_to_back();
    for (int msg_i = 0; msg_i < 4; msg_i++) begin
      logic [7:0]  bytes[$];
      logic        m;
      int          nb;
      logic [31:0] d;
      logic [3:0]  k;
      m  = 1'($urandom);
      nb = $urandom_range(1, 4);
      a_go(m);
      for (int b = 0; b < nb; b++) begin
        d = $urandom;
        k = 4'($urandom);
        for (int j = 0; j < 4; j++) begin
          if (k[j]) bytes.push_back(d[8*j +: 8]);
        end
        if (b == nb - 1) a_q.push_back(mk({32'd0, ref_fnv32(m, bytes)}, 32'(bytes.size())));
        a_beat(d, k, "rand_beat");
      end
      a_end("rand_msg");
    end
  endtask

  initial begin
    #200us;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    a_rst = 1'b1; a_start = 1'b0; a_mode = 1'b0; a_fdr = 1'b0; a_eof = 1'b0;
    a_data = '0; a_keep = '0;
    s_rst = 1'b1; s_start = 1'b0; s_mode = 1'b0; s_fdr = 1'b0; s_eof = 1'b0;
    s_data = '0; s_keep = '0;
    test_reset();
    test_empty();
    test_single_a();
    test_foobar(1'b0);
    test_foobar(1'b1);
    test_start_ignored();
    test_reset_mid();
    test_keep_zero();
    test_back_to_back();
    total++;
    if (a_q.size() != 0 || b_q.size() != 0 || c_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: %0d/%0d/%0d expectations unconsumed, required 0", a_q.size(), b_q.size(), c_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
